// File: rtl/dl1_line_adapter.sv
// Miss handler between the 2-way DataL1 cache and the memory word bus: dirty-victim writeback then line fill.
// Optional miss/writeback counters are built only when DL1_PERF_CNT_EN is defined.
module dl1_line_adapter #(
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cache_hit,
  input  logic                 cache_dirty,
  input  logic [ADDR_SIZE-1:0] cache_aout,
  input  logic [WORD_SIZE-1:0] cache_dout,
  output logic                 cache_owns,
  output logic [ADDR_SIZE-1:0] cache_addr,
  output logic                 cache_we_cache,
  output logic [WORD_SIZE-1:0] cache_data,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
);

  localparam int unsigned WIDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(WORDS_PER_LINE * 4 - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_RD    = 3'd1,
    WB_REQ   = 3'd2,
    FILL_REQ = 3'd3,
    FILL_WR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic [ADDR_SIZE-1:0]  line_base_q, line_base_d;
  logic [ADDR_SIZE-1:0]  vict_base_q, vict_base_d;
  logic [WORD_SIZE-1:0]  wbuf_q, wbuf_d;
  logic [WORD_SIZE-1:0]  fbuf_q, fbuf_d;

  logic [ADDR_SIZE-1:0]  word_off;
  logic [ADDR_SIZE-1:0]  vict_addr;
  logic [ADDR_SIZE-1:0]  line_addr;
  logic                  miss;
  logic                  widx_last;

  assign word_off  = ADDR_SIZE'({widx_q, 2'b00});
  assign vict_addr = vict_base_q + word_off;
  assign line_addr = line_base_q + word_off;
  assign miss      = (cpu_re | cpu_we) & ~cache_hit;
  assign widx_last = (widx_q == WIDX_LAST);

  // Stall covers the miss cycle itself, before the FSM has left IDLE.
  assign stall = (state_q != IDLE) | miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      line_base_q <= '0;
      vict_base_q <= '0;
      wbuf_q      <= '0;
      fbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      line_base_q <= line_base_d;
      vict_base_q <= vict_base_d;
      wbuf_q      <= wbuf_d;
      fbuf_q      <= fbuf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    line_base_d = line_base_q;
    vict_base_d = vict_base_q;
    wbuf_d      = wbuf_q;
    fbuf_d      = fbuf_q;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          line_base_d = cpu_addr & ~OFF_MASK;
          vict_base_d = cache_aout;
          widx_d      = '0;
          state_d     = cache_dirty ? WB_RD : FILL_REQ;
        end
      end
      WB_RD: begin
        wbuf_d  = cache_dout;
        state_d = WB_REQ;
      end
      WB_REQ: begin
        if (mem_ack) begin
          if (widx_last) begin
            widx_d  = '0;
            state_d = FILL_REQ;
          end else begin
            widx_d  = widx_q + WIDX_W'(1);
            state_d = WB_RD;
          end
        end
      end
      FILL_REQ: begin
        if (mem_ack) begin
          fbuf_d  = mem_rdata;
          state_d = FILL_WR;
        end
      end
      FILL_WR: begin
        // Valid is set by the cache on the last word, so order must stay ascending.
        if (widx_last) begin
          state_d = IDLE;
        end else begin
          widx_d  = widx_q + WIDX_W'(1);
          state_d = FILL_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cache_owns     = (state_q != IDLE);
    cache_addr     = '0;
    cache_we_cache = 1'b0;
    cache_data     = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    unique case (state_q)
      WB_RD:    cache_addr = vict_addr;
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vict_addr[ADDR_SIZE-1:2], 2'b00};
        mem_wdata = wbuf_q;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line_addr[ADDR_SIZE-1:2], 2'b00};
      end
      FILL_WR: begin
        cache_we_cache = 1'b1;
        cache_addr     = line_addr;
        cache_data     = fbuf_q;
      end
      default: ;
    endcase
  end

`ifdef DL1_PERF_CNT_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;
  logic        miss_start;
  logic        wb_start;

  assign miss_start = (state_q == IDLE) && (state_d != IDLE);
  assign wb_start   = (state_q == IDLE) && (state_d == WB_RD);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_start && (wb_cnt_q != 32'hFFFF_FFFF))     wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign miss_cnt = 32'd0;
  assign wb_cnt   = 32'd0;
`endif

endmodule
